alu_wide_sequencer: RTL and testbench

ALU_WIDE_SEQUENCER -- requirements
Module: alu_wide_sequencer

---
 rtl/alu_wide_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_wide_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// Sequences one 16-bit operation as two dependent 8-bit ALU operations,
// low byte first, then returns the combined result through a valid/ready handshake.
module alu_wide_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqOp,
  input  logic [15:0] ReqLhs,
  input  logic [15:0] ReqRhs,
  output logic [3:0]  AluOp,
  output logic [7:0]  AluLhs,
  output logic [7:0]  AluRhs,
  input  logic [7:0]  AluResult,
  input  logic        AluCarryOut,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [15:0] RespResult,
  output logic        RespCarry,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CAP  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic [2:0] OP_DEC16 = 3'd3;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] lhs_q;
  logic [15:0] rhs_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [7:0]  alu_lhs_q, alu_lhs_d;
  logic [7:0]  alu_rhs_q, alu_rhs_d;
  logic        accept_s;

  function automatic logic [3:0] lo_opcode(input logic [2:0] op);
    case (op)
      3'd0:    lo_opcode = 4'd3;
      3'd1:    lo_opcode = 4'd7;
      3'd2:    lo_opcode = 4'd5;
      3'd3:    lo_opcode = 4'd9;
      3'd4:    lo_opcode = 4'd10;
      3'd5:    lo_opcode = 4'd11;
      3'd6:    lo_opcode = 4'd12;
      default: lo_opcode = 4'd13;
    endcase
  endfunction

  // High-byte opcodes consume the carry/borrow left by the low-byte step.
  function automatic logic [3:0] hi_opcode(input logic [2:0] op);
    case (op)
      3'd0:    hi_opcode = 4'd4;
      3'd1:    hi_opcode = 4'd8;
      3'd2:    hi_opcode = 4'd6;
      3'd3:    hi_opcode = 4'd8;
      3'd4:    hi_opcode = 4'd10;
      3'd5:    hi_opcode = 4'd11;
      3'd6:    hi_opcode = 4'd12;
      default: hi_opcode = 4'd13;
    endcase
  endfunction

  assign accept_s = (state_q == S_IDLE) && ReqValid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ReqValid) state_d = S_LO;
        else          state_d = S_IDLE;
      end
      S_LO:   state_d = S_HI;
      S_HI:   state_d = S_CAP;
      S_CAP:  state_d = S_RESP;
      S_RESP: begin
        if (RespReady) state_d = S_IDLE;
        else           state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive is registered from the next state, so it lines up with state_q.
  always_comb begin
    alu_op_d  = 4'd0;
    alu_lhs_d = 8'h00;
    alu_rhs_d = 8'h00;
    case (state_d)
      S_LO: begin
        alu_op_d  = lo_opcode(ReqOp);
        alu_lhs_d = ReqLhs[7:0];
        alu_rhs_d = ReqRhs[7:0];
      end
      S_HI: begin
        alu_op_d  = hi_opcode(op_q);
        alu_lhs_d = lhs_q[15:8];
        if (op_q == OP_DEC16) alu_rhs_d = 8'h00;
        else                  alu_rhs_d = rhs_q[15:8];
      end
      default: begin
        alu_op_d  = 4'd0;
        alu_lhs_d = 8'h00;
        alu_rhs_d = 8'h00;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      lhs_q     <= 16'h0000;
      rhs_q     <= 16'h0000;
      result_q  <= 16'h0000;
      carry_q   <= 1'b0;
      alu_op_q  <= 4'd0;
      alu_lhs_q <= 8'h00;
      alu_rhs_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      alu_lhs_q <= alu_lhs_d;
      alu_rhs_q <= alu_rhs_d;
      if (accept_s) begin
        op_q  <= ReqOp;
        lhs_q <= ReqLhs;
        rhs_q <= ReqRhs;
      end
      // The ALU answers one cycle late: low byte is seen in HI, high byte in CAP.
      if (state_q == S_HI) result_q[7:0] <= AluResult;
      if (state_q == S_CAP) begin
        result_q[15:8] <= AluResult;
        carry_q        <= AluCarryOut;
      end
    end
  end

  assign ReqReady   = (state_q == S_IDLE);
  assign Busy       = ~ReqReady;
  assign RespValid  = (state_q == S_RESP);
  assign RespResult = result_q;
  assign RespCarry  = carry_q;
  assign AluOp      = alu_op_q;
  assign AluLhs     = alu_lhs_q;
  assign AluRhs     = alu_rhs_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer with a behavioural 8-bit ALU that
// answers one cycle after each opcode; expected values are hand-computed.
module tb_alu_wide_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqOp;
  logic [15:0] ReqLhs;
  logic [15:0] ReqRhs;
  logic [3:0]  AluOp;
  logic [7:0]  AluLhs;
  logic [7:0]  AluRhs;
  logic [7:0]  AluResult;
  logic        AluCarryOut;
  logic        RespValid;
  logic        RespReady;
  logic [15:0] RespResult;
  logic        RespCarry;
  logic        Busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_wide_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqOp      (ReqOp),
    .ReqLhs     (ReqLhs),
    .ReqRhs     (ReqRhs),
    .AluOp      (AluOp),
    .AluLhs     (AluLhs),
    .AluRhs     (AluRhs),
    .AluResult  (AluResult),
    .AluCarryOut(AluCarryOut),
    .RespValid  (RespValid),
    .RespReady  (RespReady),
    .RespResult (RespResult),
    .RespCarry  (RespCarry),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  // Returns {carry, result}; subtract-type ops report borrow in the carry bit.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] l,
                                       input logic [7:0] r, input logic cin);
    case (op)
      4'd3:    alu_f = {1'b0, l} + {1'b0, r};
      4'd4:    alu_f = {1'b0, l} + {1'b0, r} + {8'd0, cin};
      4'd5:    alu_f = {1'b0, l} + 9'd1;
      4'd6:    alu_f = {1'b0, l} + {8'd0, cin};
      4'd7:    alu_f = {1'b0, l} - {1'b0, r};
      4'd8:    alu_f = {1'b0, l} - {1'b0, r} - {8'd0, cin};
      4'd9:    alu_f = {1'b0, l} - 9'd1;
      4'd10:   alu_f = {1'b0, l & r};
      4'd11:   alu_f = {1'b0, l | r};
      4'd12:   alu_f = {1'b0, l ^ r};
      4'd13:   alu_f = {1'b0, ~l};
      default: alu_f = 9'd0;
    endcase
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      AluResult   <= 8'h00;
      AluCarryOut <= 1'b0;
    end else begin
      {AluCarryOut, AluResult} <= alu_f(AluOp, AluLhs, AluRhs, AluCarryOut);
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] lhs,
                        input logic [15:0] rhs, input logic [3:0] e_lo, input logic [3:0] e_hi,
                        input logic [7:0] e_hi_rhs, input logic [15:0] e_res, input logic e_c,
                        input int stall, input bit early_ready);
    ReqValid  = 1'b1;
    ReqOp     = op;
    ReqLhs    = lhs;
    ReqRhs    = rhs;
    RespReady = early_ready;
    #1 check_value({tag, " idle ready"}, {31'd0, ReqReady}, 32'd1);
    @(negedge Clock);
    ReqValid = 1'b0;
    ReqLhs   = 16'hDEAD;
    ReqRhs   = 16'hBEEF;
    check_value({tag, " lo op"}, {28'd0, AluOp}, {28'd0, e_lo});
    check_value({tag, " lo lhs"}, {24'd0, AluLhs}, {24'd0, lhs[7:0]});
    check_value({tag, " lo busy"}, {30'd0, Busy, ReqReady}, 32'd2);
    @(negedge Clock);
    check_value({tag, " hi op"}, {28'd0, AluOp}, {28'd0, e_hi});
    check_value({tag, " hi lhs/rhs"}, {16'd0, AluLhs, AluRhs}, {16'd0, lhs[15:8], e_hi_rhs});
    @(negedge Clock);
    check_value({tag, " cap idle alu"}, {12'd0, AluOp, AluLhs, AluRhs}, 32'd0);
    check_value({tag, " cap no resp"}, {31'd0, RespValid}, 32'd0);
    @(negedge Clock);
    check_value({tag, " resp valid"}, {31'd0, RespValid}, 32'd1);
    check_value({tag, " resp data"}, {15'd0, RespCarry, RespResult}, {15'd0, e_c, e_res});
    for (int i = 0; i < stall; i++) begin
      ReqValid = (i == 1);
      ReqOp    = 3'd0;
      @(negedge Clock);
      ReqValid = 1'b0;
      check_value({tag, " stall hold"}, {14'd0, RespValid, RespCarry, RespResult},
                  {14'd0, 1'b1, e_c, e_res});
      check_value({tag, " stall quiet"}, {27'd0, ReqReady, AluOp}, 32'd0);
    end
    RespReady = 1'b1;
    @(negedge Clock);
    RespReady = 1'b0;
    check_value({tag, " done"}, {27'd0, RespValid, ReqReady, Busy, 2'b00}, 32'b01000);
    check_value({tag, " kept"}, {11'd0, AluOp, RespCarry, RespResult}, {15'd0, e_c, e_res});
  endtask

  initial begin
    Reset     = 1'b1;
    ReqValid  = 1'b0;
    ReqOp     = 3'd0;
    ReqLhs    = 16'h0000;
    ReqRhs    = 16'h0000;
    RespReady = 1'b0;
    @(negedge Clock);
    check_value("reset ready/busy/valid", {29'd0, ReqReady, Busy, RespValid}, 32'b100);
    check_value("reset alu", {12'd0, AluOp, AluLhs, AluRhs}, 32'd0);
    check_value("reset resp", {15'd0, RespCarry, RespResult}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check_value("post reset idle", {30'd0, ReqReady, RespValid}, 32'b10);

    run_op("add16",     3'd0, 16'h12FF, 16'h0001, 4'd3,  4'd4,  8'h00, 16'h1300, 1'b0, 0, 1'b0);
    run_op("inc16",     3'd2, 16'hFFFF, 16'h1234, 4'd5,  4'd6,  8'h12, 16'h0000, 1'b1, 0, 1'b0);
    run_op("dec16",     3'd3, 16'h0100, 16'h5678, 4'd9,  4'd8,  8'h00, 16'h00FF, 1'b0, 0, 1'b0);
    run_op("xor16",     3'd6, 16'hA5A5, 16'hFF00, 4'd12, 4'd12, 8'hFF, 16'h5AA5, 1'b0, 5, 1'b0);
    run_op("sub16",     3'd1, 16'h1000, 16'h0001, 4'd7,  4'd8,  8'h00, 16'h0FFF, 1'b0, 0, 1'b0);
    run_op("sub16 wrap",3'd1, 16'h0000, 16'h0001, 4'd7,  4'd8,  8'h00, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op("and16",     3'd4, 16'hF0F0, 16'h3C3C, 4'd10, 4'd10, 8'h3C, 16'h3030, 1'b0, 0, 1'b0);
    run_op("or16 early",3'd5, 16'h0F00, 16'h00F0, 4'd11, 4'd11, 8'h00, 16'h0FF0, 1'b0, 0, 1'b1);
    run_op("not16",     3'd7, 16'h1234, 16'hABCD, 4'd13, 4'd13, 8'hAB, 16'hEDCB, 1'b0, 0, 1'b0);
    run_op("add16 wrap",3'd0, 16'hFFFF, 16'h0001, 4'd3,  4'd4,  8'h00, 16'h0000, 1'b1, 0, 1'b0);
    run_op("dec16 b",   3'd3, 16'h8000, 16'h0000, 4'd9,  4'd8,  8'h00, 16'h7FFF, 1'b0, 0, 1'b0);

    // Abort an ADD16 in HI with Reset; nothing may come back from it.
    ReqValid = 1'b1;
    ReqOp    = 3'd0;
    ReqLhs   = 16'h1111;
    ReqRhs   = 16'h2222;
    @(negedge Clock);
    ReqValid = 1'b0;
    @(negedge Clock);
    check_value("abort in hi", {28'd0, AluOp}, 32'd4);
    Reset = 1'b1;
    #1;
    check_value("abort ready/busy/valid", {29'd0, ReqReady, Busy, RespValid}, 32'b100);
    check_value("abort alu", {12'd0, AluOp, AluLhs, AluRhs}, 32'd0);
    check_value("abort resp", {15'd0, RespCarry, RespResult}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check_value("abort no resp", {27'd0, RespValid, ReqReady, AluOp}, 32'b010000);
    end

    // ReqValid held during Reset must not be taken until Reset drops.
    Reset    = 1'b1;
    ReqValid = 1'b1;
    ReqOp    = 3'd6;
    @(negedge Clock);
    check_value("no accept in reset", {27'd0, ReqReady, AluOp}, 32'b10000);
    Reset = 1'b0;
    run_op("after reset", 3'd6, 16'h0FF0, 16'h00FF, 4'd12, 4'd12, 8'h00, 16'h0F0F, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
